// File: rtl/v_reg_seq.sv
//------------------------------------------------------------------------------
// Module      : v_reg_seq
// Description : Element sequencer for a banked vector register file. It steps
//               each op's elements in lane-wide groups for reads, then repeats
//               the same groups as writes after a fixed execution latency.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module v_reg_seq #(
    parameter  int VLEN     = 8,
    parameter  int LANES    = 4,
    parameter  int EXEC_LAT = 2,
    localparam int AW       = (VLEN > 1) ? $clog2(VLEN) : 1,
    localparam int GROUPS   = VLEN / LANES
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [AW:0]                vl_i,
    input  logic                       we_i,
    output logic                       ready_o,
    output logic [LANES-1:0][AW-1:0]   r_addr_o,
    output logic [LANES-1:0]           r_en_o,
    output logic [LANES-1:0][AW-1:0]   w_addr_o,
    output logic [LANES-1:0]           w_en_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int DW = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;
    localparam int EW = AW + 1;

    localparam logic [EW-1:0] C_VLEN     = EW'(VLEN);
    localparam logic [EW-1:0] C_LANES    = EW'(LANES);
    localparam logic [DW-1:0] C_DRAIN_LT = DW'(EXEC_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [GW-1:0]   r_g;
    logic [GW-1:0]   r_glast;
    logic [EW-1:0]   r_vle;
    logic            r_we;
    logic [DW-1:0]   r_dcnt;

    // Write-back pipeline: one slot per cycle of execution latency.
    logic            r_pv [EXEC_LAT];
    logic [GW-1:0]   r_pg [EXEC_LAT];
    logic [LANES-1:0] r_pm [EXEC_LAT];

    logic [EW-1:0]   w_vle_in;
    logic [GW-1:0]   w_glast_in;
    logic            w_accept;
    logic            w_issue;
    logic            w_last_grp;
    logic            w_drain_end;
    logic [LANES-1:0] w_rmask;
    logic [EW-1:0]   w_relem [LANES];

    assign w_vle_in    = (vl_i > C_VLEN) ? C_VLEN : vl_i;
    assign w_glast_in  = GW'((w_vle_in - EW'(1)) / C_LANES);
    assign w_accept    = v_i && (r_state == S_IDLE);
    assign w_issue     = (r_state == S_ISSUE);
    assign w_last_grp  = (r_g == r_glast);
    assign w_drain_end = (r_dcnt == C_DRAIN_LT);

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign w_relem[i]  = EW'(r_g) * C_LANES + EW'(i);
            assign w_rmask[i]  = (w_relem[i] < r_vle);
            assign r_addr_o[i] = w_issue ? w_relem[i][AW-1:0] : '0;
            assign r_en_o[i]   = w_issue && w_rmask[i];
            assign w_addr_o[i] = r_pv[EXEC_LAT-1]
                               ? AW'(EW'(r_pg[EXEC_LAT-1]) * C_LANES + EW'(i))
                               : '0;
        end
    endgenerate

    assign w_en_o  = r_pm[EXEC_LAT-1];
    assign ready_o = (r_state == S_IDLE);
    assign busy_o  = (r_state != S_IDLE);
    assign done_o  = (r_state == S_DONE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = (w_vle_in == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: if (w_last_grp) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drain_end) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
            r_g     <= '0;
            r_glast <= '0;
            r_vle   <= '0;
            r_we    <= 1'b0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_g     <= '0;
                r_glast <= w_glast_in;
                r_vle   <= w_vle_in;
                r_we    <= we_i;
            end else if (w_issue && !w_last_grp) begin
                r_g <= r_g + GW'(1);
            end
            if (r_state == S_DRAIN) begin
                r_dcnt <= r_dcnt + DW'(1);
            end else begin
                r_dcnt <= '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int s = 0; s < EXEC_LAT; s++) begin
                r_pv[s] <= 1'b0;
                r_pg[s] <= '0;
                r_pm[s] <= '0;
            end
        end else begin
            r_pv[0] <= w_issue;
            r_pg[0] <= w_issue ? r_g : '0;
            r_pm[0] <= (w_issue && r_we) ? w_rmask : '0;
            for (int s = 1; s < EXEC_LAT; s++) begin
                r_pv[s] <= r_pv[s-1];
                r_pg[s] <= r_pg[s-1];
                r_pm[s] <= r_pm[s-1];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_v_reg_seq.sv
//------------------------------------------------------------------------------
// Module      : tb_v_reg_seq
// Description : Directed self-checking bench for v_reg_seq (8 elems, 4 lanes,
//               latency 2).
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_v_reg_seq;

    localparam int C_LAT = 2;

    logic             clk_i;
    logic             reset_n_i;
    logic             v_i;
    logic [3:0]       vl_i;
    logic             we_i;
    logic             ready_o;
    logic [3:0][2:0]  r_addr_o;
    logic [3:0]       r_en_o;
    logic [3:0][2:0]  w_addr_o;
    logic [3:0]       w_en_o;
    logic             busy_o;
    logic             done_o;

    int n_checks = 0;
    int n_fail   = 0;

    v_reg_seq dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .vl_i      (vl_i),
        .we_i      (we_i),
        .ready_o   (ready_o),
        .r_addr_o  (r_addr_o),
        .r_en_o    (r_en_o),
        .w_addr_o  (w_addr_o),
        .w_en_o    (w_en_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] grp_addr(input int g);
        logic [11:0] a;
        for (int i = 0; i < 4; i++) a[i*3 +: 3] = 3'(g * 4 + i);
        return a;
    endfunction

    function automatic logic [3:0] grp_mask(input int g, input int vle);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = (g * 4 + i < vle);
        return m;
    endfunction

    // Accept an op at the end of cycle 0 and check every cycle until idle again.
    task automatic run_op(input int vl, input bit we);
        int vle, grps, done_c, c, wg;
        vle    = (vl > 8) ? 8 : vl;
        grps   = (vle + 3) / 4;
        done_c = (vle == 0) ? 1 : grps + C_LAT + 1;
        @(negedge clk_i);
        check_val("ready_c0", 32'(ready_o), 32'd1);
        v_i = 1'b1; vl_i = 4'(vl); we_i = we;
        for (c = 1; c <= done_c + 1; c++) begin
            @(negedge clk_i);
            v_i = 1'b0;
            if (c >= 1 && c <= grps) begin
                check_val("r_en", 32'(r_en_o), 32'(grp_mask(c - 1, vle)));
                check_val("r_addr", 32'(r_addr_o), 32'(grp_addr(c - 1)));
            end else begin
                check_val("r_en_idle", 32'(r_en_o), 32'd0);
            end
            wg = c - 1 - C_LAT;
            if (wg >= 0 && wg < grps) begin
                check_val("w_en", 32'(w_en_o), we ? 32'(grp_mask(wg, vle)) : 32'd0);
                check_val("w_addr", 32'(w_addr_o), 32'(grp_addr(wg)));
            end else begin
                check_val("w_en_idle", 32'(w_en_o), 32'd0);
            end
            check_val("done", 32'(done_o), 32'(c == done_c));
            check_val("ready", 32'(ready_o), 32'(c == done_c + 1));
            check_val("busy", 32'(busy_o), 32'(c <= done_c));
        end
    endtask

    initial begin
        reset_n_i = 1'b0; v_i = 1'b0; vl_i = '0; we_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check_val("rst_ready", 32'(ready_o), 32'd1);
        check_val("rst_busy", 32'(busy_o), 32'd0);
        check_val("rst_done", 32'(done_o), 32'd0);
        check_val("rst_ren", 32'(r_en_o), 32'd0);
        check_val("rst_wen", 32'(w_en_o), 32'd0);
        check_val("rst_raddr", 32'(r_addr_o), 32'd0);
        check_val("rst_waddr", 32'(w_addr_o), 32'd0);
        reset_n_i = 1'b1;

        // Scenario 1: hand-written cycle by cycle.
        @(negedge clk_i);
        v_i = 1'b1; vl_i = 4'd8; we_i = 1'b1;
        @(negedge clk_i); v_i = 1'b0;
        check_val("s1_c1_raddr", 32'(r_addr_o), 32'h688);
        check_val("s1_c1_ren", 32'(r_en_o), 32'hF);
        check_val("s1_c1_ready", 32'(ready_o), 32'd0);
        @(negedge clk_i);
        check_val("s1_c2_raddr", 32'(r_addr_o), 32'hFAC);
        check_val("s1_c2_ren", 32'(r_en_o), 32'hF);
        @(negedge clk_i);
        check_val("s1_c3_waddr", 32'(w_addr_o), 32'h688);
        check_val("s1_c3_wen", 32'(w_en_o), 32'hF);
        check_val("s1_c3_ren", 32'(r_en_o), 32'h0);
        @(negedge clk_i);
        check_val("s1_c4_waddr", 32'(w_addr_o), 32'hFAC);
        check_val("s1_c4_wen", 32'(w_en_o), 32'hF);
        @(negedge clk_i);
        check_val("s1_c5_done", 32'(done_o), 32'd1);
        check_val("s1_c5_busy", 32'(busy_o), 32'd1);
        check_val("s1_c5_wen", 32'(w_en_o), 32'h0);
        @(negedge clk_i);
        check_val("s1_c6_ready", 32'(ready_o), 32'd1);
        check_val("s1_c6_done", 32'(done_o), 32'd0);

        // Scenario 2: partial last group.
        run_op(5, 1'b1);
        // Scenario 3: zero length.
        run_op(0, 1'b1);
        // Scenario 4: clamped length, then the same op without write-back.
        run_op(12, 1'b1);
        run_op(12, 1'b0);
        run_op(3, 1'b1);
        run_op(15, 1'b1);

        // Scenario 5: valid held through a busy op.
        @(negedge clk_i);
        v_i = 1'b1; vl_i = 4'd8; we_i = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_i);
            check_val("s5_ready_low", 32'(ready_o), 32'd0);
        end
        @(negedge clk_i);
        check_val("s5_c6_ready", 32'(ready_o), 32'd1);
        @(negedge clk_i);
        check_val("s5_c7_ren", 32'(r_en_o), 32'hF);
        check_val("s5_c7_raddr", 32'(r_addr_o), 32'h688);
        @(negedge clk_i);
        v_i = 1'b0;
        check_val("s5_c8_ren", 32'(r_en_o), 32'hF);
        check_val("s5_c8_raddr", 32'(r_addr_o), 32'hFAC);
        repeat (4) @(negedge clk_i);
        check_val("s5_c12_ready", 32'(ready_o), 32'd1);

        // Scenario 6: reset during cycle 2 abandons the op.
        @(negedge clk_i);
        v_i = 1'b1; vl_i = 4'd8; we_i = 1'b1;
        @(negedge clk_i); v_i = 1'b0;
        @(negedge clk_i);
        check_val("s6_c2_ren", 32'(r_en_o), 32'hF);
        reset_n_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        check_val("s6_c3_ready", 32'(ready_o), 32'd1);
        check_val("s6_c3_busy", 32'(busy_o), 32'd0);
        for (int c = 3; c <= 8; c++) begin
            if (c > 3) @(negedge clk_i);
            check_val("s6_ren", 32'(r_en_o), 32'd0);
            check_val("s6_wen", 32'(w_en_o), 32'd0);
            check_val("s6_done", 32'(done_o), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
